// File: rtl/univ_sft_register.sv
// Universal shift register: parallel load/clear plus multi-cycle logical, arithmetic
// and rotate shifts executed one bit per clock, behind a valid/ready command handshake.
module univ_sft_register #(
   parameter  int WIDTH = 9,
   localparam int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] sft_reg_in,
   input  logic             ser_in,
   output logic [WIDTH-1:0] sft_reg_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_e;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_LOAD  = 3'b001,
      OP_SHL   = 3'b010,
      OP_SHR   = 3'b011,
      OP_SAR   = 3'b100,
      OP_ROL   = 3'b101,
      OP_ROR   = 3'b110,
      OP_CLEAR = 3'b111
   } op_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [AMT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   reg_q, reg_d;
   logic               ser_q, ser_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     stepped;

   // Returns {bit shifted out, new register value} for one 1-bit step.
   function automatic logic [WIDTH:0] step(input op_e op, input logic [WIDTH-1:0] r,
                                           input logic si);
      case (op)
         OP_SHL:  return {r[WIDTH-1], r[WIDTH-2:0], si};
         OP_SHR:  return {r[0], si, r[WIDTH-1:1]};
         OP_SAR:  return {r[0], r[WIDTH-1], r[WIDTH-1:1]};
         OP_ROL:  return {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
         OP_ROR:  return {r[0], r[0], r[WIDTH-1:1]};
         default: return {1'b0, r};
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      reg_d   = reg_q;
      ser_d   = ser_q;
      done_d  = 1'b0;
      stepped = step(op_q, reg_q, ser_in);
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (op_e'(cmd_op))
                  OP_NOP: done_d = 1'b1;
                  OP_LOAD: begin
                     reg_d  = sft_reg_in;
                     done_d = 1'b1;
                  end
                  OP_CLEAR: begin
                     reg_d  = '0;
                     done_d = 1'b1;
                  end
                  default: begin
                     if (cmd_amt == '0) begin
                        done_d = 1'b1;
                     end else begin
                        op_d    = op_e'(cmd_op);
                        count_d = cmd_amt;
                        state_d = RUN;
                     end
                  end
               endcase
            end
         end
         RUN: begin
            {ser_d, reg_d} = stepped;
            count_d        = count_q - AMT_W'(1);
            if (count_q == AMT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         count_q <= '0;
         reg_q   <= '0;
         ser_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         reg_q   <= reg_d;
         ser_q   <= ser_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q == RUN);
   assign sft_reg_out = reg_q;
   assign ser_out     = ser_q;
   assign done        = done_q;

endmodule

// File: doc/univ_sft_register.md
Name: univ_sft_register

Overview:
- Parametrised universal shift register and the successor to the fixed 9-bit left/right shift register.
- Adds a command handshake, multi-bit shift amounts executed one bit per cycle, and arithmetic, rotate and serial-fill modes.
- Provides serial in/out, busy and done status.
- Sits between the control FSM and the datapath; the FSM issues one command at a time and waits for done.

Parameters:
- WIDTH, 9: register width in bits, minimum 2.
- AMT_W, $clog2(WIDTH)+1: width of the shift-amount field (derived; do not override).

Ports:
- sys_clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_op  input  3  opcode: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 SAR, 101 ROL, 110 ROR, 111 CLEAR.
- cmd_amt  input  AMT_W  shift count for opcodes 010..110; ignored otherwise.
- sft_reg_in  input  WIDTH  parallel load data.
- ser_in  input  1  serial fill bit; LSB for SHL, MSB for SHR.
- sft_reg_out  output  WIDTH  register contents.
- ser_out  output  1  bit most recently shifted or rotated out.
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset
  - rst sampled high at an edge: sft_reg_out=0, ser_out=0, busy=0, done=0, state=IDLE, count=0.
  - Reset overrides any in-flight command and any cmd_valid at the same edge.
  - A command aborted by reset produces no done.
- Accept and FSM
  - Command is accepted at an edge where cmd_valid & cmd_ready; fields are sampled at that edge only.
  - States: IDLE, RUN.
  - cmd_ready = (state==IDLE); busy = (state==RUN).
  - cmd_valid while busy is ignored, with no effect and no queuing.
- Single-cycle opcodes (NOP, LOAD, CLEAR, or any shift opcode with cmd_amt=0)
  - Executed at the accept edge; state stays IDLE.
  - done=1 for the following cycle.
  - LOAD writes sft_reg_in; CLEAR writes 0; NOP and amt=0 leave the register unchanged.
  - ser_out is unchanged.
- Shift opcodes with cmd_amt=k>=1
  - Accept edge: latch op and count=k, go to RUN; no data change at this edge.
  - Each subsequent edge in RUN performs exactly one 1-bit step and decrements count.
  - On the edge where count==1: step, go to IDLE, done=1 for the next cycle.
  - Latency: final value and done are visible k edges after the accept edge; busy is high for exactly k cycles.
  - A new command is accepted on the cycle done is high (back-to-back allowed).
- Step definitions (r = register)
  - SHL: r={r[W-2:0],ser_in}, ser_out=r[W-1].
  - SHR: r={ser_in,r[W-1:1]}, ser_out=r[0].
  - SAR: r={r[W-1],r[W-1:1]}, ser_out=r[0].
  - ROL: r={r[W-2:0],r[W-1]}, ser_out=r[W-1].
  - ROR: r={r[0],r[W-1:1]}, ser_out=r[0].
- ser_in is sampled at each step edge, not at accept.
- k may exceed WIDTH (up to 2^AMT_W-1)
  - Logical shifts keep filling from ser_in.
  - Rotates by WIDTH restore the original value.
  - No saturation or modulo.
- done is never high in the same cycle as busy. Outputs hold their value whenever no step, load or clear occurs.

Test Plan:
- Reset: rst=1 for 2 edges with cmd_valid=1/LOAD -> sft_reg_out=0, ser_out=0, cmd_ready=1, busy=0, done=0.
- Load then left shift:
  - LOAD 9'h1A5 -> next cycle sft_reg_out=9'h1A5, done=1 for exactly one cycle.
  - Then LOAD 9'h0F0, SHL amt=3 with ser_in=1 -> intermediate values 9'h1E1, 9'h1C3, final 9'h187; ser_out=1; busy=1 for 3 cycles; done one cycle after the 3rd step.
- Arithmetic right: LOAD 9'h100, SAR amt=4 -> 9'h1F0, ser_out=0; then SHR amt=2 with ser_in=0 -> 9'h07C.
- Rotates:
  - LOAD 9'h001, ROR amt=1 -> 9'h100, ser_out=1.
  - LOAD 9'h1A5, ROL amt=9 -> 9'h1A5 after 9 busy cycles.
- Boundaries:
  - SHL amt=0 -> value unchanged, done next cycle, busy never high.
  - Back-to-back command presented on the done cycle is accepted.
  - cmd_valid LOAD during busy -> ignored, register unaffected.
- Reset mid-op: LOAD 9'h1FF, SHL amt=8, assert rst after 2 steps -> next cycle sft_reg_out=0, busy=0, cmd_ready=1, no done pulse.
